// File: rtl/tungsten_scatter_if.sv
// ============================================================================
// Module  : tungsten_scatter_if
// Purpose : Beat input and frame output bundle of the tungsten scatter block.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface tungsten_scatter_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_sel;
  logic [7:0] in_data;
  logic       clear;
  logic       frame_valid;
  logic       frame_ready;
  logic [7:0] frame_data;
  logic [7:0] cover_mask;
  logic [7:0] collisions;

  modport master (
    output in_valid, in_sel, in_data, clear, frame_ready,
    input  in_ready, frame_valid, frame_data, cover_mask, collisions
  );

  modport slave (
    input  in_valid, in_sel, in_data, clear, frame_ready,
    output in_ready, frame_valid, frame_data, cover_mask, collisions
  );
endinterface

`default_nettype wire

// File: rtl/tungsten_scatter.sv
// ============================================================================
// Module  : tungsten_scatter
// Purpose : Scatters eight lane bits into a frame register at sliding-window
//           addresses and emits the frame once every bit has been written.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tungsten_scatter (
  input  wire                  clk,
  input  wire                  rst,
  tungsten_scatter_if.slave    bus
);

  localparam logic [0:0] c_st_collect = 1'b0;
  localparam logic [0:0] c_st_emit    = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_state_next;
  logic [7:0] r_frame;
  logic [7:0] r_mask;
  logic [7:0] r_coll;

  logic [2:0] w_addr [8];
  logic [7:0] w_frame_next;
  logic [7:0] w_tgt;
  logic [7:0] w_mask_next;
  logic [3:0] w_distinct;
  logic [3:0] w_drop;
  logic [8:0] w_coll_sum;
  logic [7:0] w_coll_next;
  logic       w_in_ready;
  logic       w_frame_valid;
  logic       w_accept;
  logic       w_emit_hs;

  // Lane k reads the 3-bit window centred on select bit k, wrapping around.
  for (genvar k = 0; k < 8; k++) begin : g_lane
    assign w_addr[k] = {bus.in_sel[(k + 1) % 8], bus.in_sel[k], bus.in_sel[(k + 7) % 8]};
  end

  // Ascending lane order lets the highest-numbered lane win a shared address.
  always_comb begin
    w_frame_next = r_frame;
    w_tgt        = '0;
    for (int k = 0; k < 8; k++) begin
      w_frame_next[w_addr[k]] = bus.in_data[k];
      w_tgt[w_addr[k]]        = 1'b1;
    end
  end

  always_comb begin
    w_distinct = '0;
    for (int a = 0; a < 8; a++) begin
      w_distinct = w_distinct + {3'b000, w_tgt[a]};
    end
  end

  assign w_mask_next = r_mask | w_tgt;
  assign w_drop      = 4'd8 - w_distinct;
  assign w_coll_sum  = {1'b0, r_coll} + {5'b00000, w_drop};
  assign w_coll_next = w_coll_sum[8] ? 8'hFF : w_coll_sum[7:0];

  assign w_accept  = bus.in_valid && w_in_ready;
  assign w_emit_hs = w_frame_valid && bus.frame_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_collect;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.clear) begin
      w_state_next = c_st_collect;
    end else begin
      case (r_state)
        c_st_collect: if (w_accept && (w_mask_next == 8'hFF)) w_state_next = c_st_emit;
        c_st_emit:    if (bus.frame_ready) w_state_next = c_st_collect;
        default:      w_state_next = c_st_collect;
      endcase
    end
  end

  always_comb begin
    w_in_ready    = (r_state == c_st_collect) && !bus.clear;
    w_frame_valid = (r_state == c_st_emit);
  end

  // Clear beats both an accept and a frame handshake on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame <= '0;
      r_mask  <= '0;
      r_coll  <= '0;
    end else if (bus.clear) begin
      r_mask <= '0;
      r_coll <= '0;
    end else if (w_accept) begin
      r_frame <= w_frame_next;
      r_mask  <= w_mask_next;
      r_coll  <= w_coll_next;
    end else if (w_emit_hs) begin
      r_mask <= '0;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.frame_valid = w_frame_valid;
  assign bus.frame_data  = r_frame;
  assign bus.cover_mask  = r_mask;
  assign bus.collisions  = r_coll;

endmodule

`default_nettype wire

// File: tb/tb_tungsten_scatter.sv
// ============================================================================
// Module  : tb_tungsten_scatter
// Purpose : Self-checking bench: directed vector table, saturation and gather
//           sequences, and a randomized run against a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tungsten_scatter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  tungsten_scatter_if bus ();

  tungsten_scatter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic       clr;
    logic       valid;
    logic [7:0] sel;
    logic [7:0] data;
    logic       fready;
    logic       chk_ready;
    logic       exp_ready;
    logic       exp_fv;
    logic [7:0] exp_fd;
    logic [7:0] exp_mask;
    logic [7:0] exp_coll;
  } vec_t;

  // Behavioural reference state
  logic [7:0] m_frame;
  logic [7:0] m_mask;
  int         m_coll;
  bit         m_emit;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lane_addr(input logic [7:0] s, input int k);
    return 4 * int'(s[(k + 1) % 8]) + 2 * int'(s[k]) + int'(s[(k + 7) % 8]);
  endfunction

  function automatic bit all_distinct(input logic [7:0] s);
    bit seen [8];
    for (int a = 0; a < 8; a++) seen[a] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (seen[lane_addr(s, k)]) return 1'b0;
      seen[lane_addr(s, k)] = 1'b1;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input logic r, input logic c, input logic v,
                            input logic [7:0] s, input logic [7:0] d, input logic fr);
    int  distinct;
    bit  hit [8];
    if (r) begin
      m_frame = 8'h00; m_mask = 8'h00; m_coll = 0; m_emit = 1'b0;
    end else if (c) begin
      m_mask = 8'h00; m_coll = 0; m_emit = 1'b0;
    end else if (!m_emit && v) begin
      for (int a = 0; a < 8; a++) hit[a] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        m_frame[lane_addr(s, k)] = d[k];
        m_mask[lane_addr(s, k)]  = 1'b1;
        hit[lane_addr(s, k)]     = 1'b1;
      end
      distinct = 0;
      for (int a = 0; a < 8; a++) distinct += int'(hit[a]);
      m_coll = m_coll + (8 - distinct);
      if (m_coll > 255) m_coll = 255;
      if (m_mask == 8'hFF) m_emit = 1'b1;
    end else if (m_emit && fr) begin
      m_mask = 8'h00; m_emit = 1'b0;
    end
  endtask

  // Drives one cycle, checks in_ready in mid-cycle, leaves time at edge+1.
  task automatic drive(input logic r, input logic c, input logic v,
                       input logic [7:0] s, input logic [7:0] d, input logic fr,
                       input logic chk_rdy, input logic exp_rdy);
    rst = r; bus.clear = c; bus.in_valid = v; bus.in_sel = s; bus.in_data = d;
    bus.frame_ready = fr;
    @(negedge clk);
    if (chk_rdy) check("in_ready", int'(bus.in_ready), int'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic fv, input logic [7:0] fd,
                            input logic [7:0] mk, input logic [7:0] co);
    check({tag, " frame_valid"}, int'(bus.frame_valid), int'(fv));
    check({tag, " frame_data"},  int'(bus.frame_data),  int'(fd));
    check({tag, " cover_mask"},  int'(bus.cover_mask),  int'(mk));
    check({tag, " collisions"},  int'(bus.collisions),  int'(co));
  endtask

  task automatic model_cycle(input logic r, input logic c, input logic v,
                             input logic [7:0] s, input logic [7:0] d, input logic fr);
    drive(r, c, v, s, d, fr, !r, !m_emit && !c);
    model_step(r, c, v, s, d, fr);
    check_outs("model", m_emit, m_frame, m_mask, m_coll[7:0]);
  endtask

  vec_t       vecs [$];
  logic [7:0] db_sel [$];

  initial begin
    rst = 1'b1; bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_sel = '0;
    bus.in_data = '0; bus.frame_ready = 1'b0;

    //          rst  clr  vld  sel    data   frdy chk  rdy  fv   fd     mask   coll
    vecs.push_back('{1'b1,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,8'd0});
    vecs.push_back('{1'b0,1'b0,1'b1,8'h17,8'hA5,1'b0,1'b1,1'b1,1'b1,8'h5A,8'hFF,8'd0});
    vecs.push_back('{1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,1'b1,1'b0,1'b0,8'h5A,8'h00,8'd0});
    vecs.push_back('{1'b1,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,8'd0});
    vecs.push_back('{1'b0,1'b0,1'b1,8'h00,8'h80,1'b0,1'b1,1'b1,1'b0,8'h01,8'h01,8'd7});
    vecs.push_back('{1'b0,1'b0,1'b1,8'hFF,8'h00,1'b0,1'b1,1'b1,1'b0,8'h01,8'h81,8'd14});
    // Backpressure: frame held for three cycles with a beat waiting
    vecs.push_back('{1'b1,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,8'd0});
    vecs.push_back('{1'b0,1'b0,1'b1,8'h17,8'hA5,1'b0,1'b1,1'b1,1'b1,8'h5A,8'hFF,8'd0});
    vecs.push_back('{1'b0,1'b0,1'b1,8'h00,8'h80,1'b0,1'b1,1'b0,1'b1,8'h5A,8'hFF,8'd0});
    vecs.push_back('{1'b0,1'b0,1'b1,8'h00,8'h80,1'b0,1'b1,1'b0,1'b1,8'h5A,8'hFF,8'd0});
    vecs.push_back('{1'b0,1'b0,1'b1,8'h00,8'h80,1'b0,1'b1,1'b0,1'b1,8'h5A,8'hFF,8'd0});
    vecs.push_back('{1'b0,1'b0,1'b1,8'h00,8'h80,1'b1,1'b1,1'b0,1'b0,8'h5A,8'h00,8'd0});
    vecs.push_back('{1'b0,1'b0,1'b1,8'h00,8'h80,1'b0,1'b1,1'b1,1'b0,8'h5B,8'h01,8'd7});
    // Clear during EMIT beats the handshake; clear in COLLECT blocks the beat
    vecs.push_back('{1'b0,1'b0,1'b1,8'h17,8'hA5,1'b0,1'b1,1'b1,1'b1,8'h5A,8'hFF,8'd7});
    vecs.push_back('{1'b0,1'b1,1'b0,8'h00,8'h00,1'b1,1'b1,1'b0,1'b0,8'h5A,8'h00,8'd0});
    vecs.push_back('{1'b0,1'b1,1'b1,8'h00,8'h80,1'b0,1'b1,1'b0,1'b0,8'h5A,8'h00,8'd0});
    vecs.push_back('{1'b0,1'b0,1'b1,8'h00,8'h00,1'b0,1'b1,1'b1,1'b0,8'h5A,8'h01,8'd7});
    // Reset in the middle of an emit zeroes everything including R
    vecs.push_back('{1'b0,1'b0,1'b1,8'h17,8'hA5,1'b0,1'b1,1'b1,1'b1,8'h5A,8'hFF,8'd7});
    vecs.push_back('{1'b1,1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,1'b0,1'b0,8'h00,8'h00,8'd0});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].valid, vecs[i].sel, vecs[i].data,
            vecs[i].fready, vecs[i].chk_ready, vecs[i].exp_ready);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_fv, vecs[i].exp_fd,
                 vecs[i].exp_mask, vecs[i].exp_coll);
    end

    // Saturation: 7 dropped writes per all-zero select beat
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 36; i++) drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("sat 36 beats", int'(bus.collisions), 252);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("sat 37 beats", int'(bus.collisions), 255);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("sat 38 beats", int'(bus.collisions), 255);
    check("sat no frame", int'(bus.frame_valid), 0);

    // Gather property over every select whose eight windows are distinct
    for (int s = 0; s < 256; s++) if (all_distinct(8'(s))) db_sel.push_back(8'(s));
    check("de bruijn count", db_sel.size(), 16);
    foreach (db_sel[i]) begin
      logic [7:0] d;
      logic [7:0] g;
      d = 8'($urandom);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, db_sel[i], d, 1'b0, 1'b1, 1'b1);
      check($sformatf("gather fv sel=%02h", db_sel[i]), int'(bus.frame_valid), 1);
      for (int k = 0; k < 8; k++) g[k] = bus.frame_data[lane_addr(db_sel[i], k)];
      check($sformatf("gather sel=%02h", db_sel[i]), int'(g), int'(d));
      check($sformatf("gather coll sel=%02h", db_sel[i]), int'(bus.collisions), 0);
    end

    // Randomized regression against the reference model
    model_cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      logic       r, c, v, fr;
      logic [7:0] s;
      r  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 3) != 0);
      fr = ($urandom_range(0, 2) != 0);
      s  = ($urandom_range(0, 3) == 0) ? db_sel[$urandom_range(0, 15)] : 8'($urandom);
      model_cycle(r, c, v, s, 8'($urandom), fr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
